// File: rtl/step_controller.sv
// Clock-enable sequencer for the EDiC CPU datapath: turns the step button and
// the panel mode switches into a single microcycle enable.
module step_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                  i_oszClk,
  input  logic                  i_reset,
  input  logic                  i_btnStep,
  input  logic                  i_swInstrNCycle,
  input  logic                  i_swStepNRun,
  input  logic                  i_swEnableBreakpoint,
  input  logic [ADDR_WIDTH-1:0] i_breakpointAddress,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_instrStart,
  input  logic                  i_halt,
  output logic                  o_cpuClkEn,
  output logic                  o_running,
  output logic                  o_breakpointHit
);

  typedef enum logic [1:0] {
    IDLE,
    INSTR,
    RUN,
    BREAK
  } state_t;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  state_t           state;
  logic             issued;
  logic             skipBp;
  logic [3:0]       syncMeta;
  logic [3:0]       syncOut;
  logic             btnSync;
  logic             swInstrNCycle;
  logic             swStepNRun;
  logic             swEnableBreakpoint;
  logic [CNT_W-1:0] debounceCnt;
  logic             btnStable;
  logic             btnStableQ;
  logic             stepReq;
  logic             bpMatch;

  // Two-flop synchronizers for the button and the three panel switches.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      syncMeta <= '0;
      syncOut  <= '0;
    end else begin
      syncMeta <= {i_btnStep, i_swInstrNCycle, i_swStepNRun, i_swEnableBreakpoint};
      syncOut  <= syncMeta;
    end
  end

  assign {btnSync, swInstrNCycle, swStepNRun, swEnableBreakpoint} = syncOut;

  // A new button level is accepted only after DEBOUNCE_CYCLES consecutive
  // differing samples; any agreeing sample restarts the count.
  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      debounceCnt <= '0;
      btnStable   <= 1'b0;
      btnStableQ  <= 1'b0;
    end else begin
      btnStableQ <= btnStable;
      if (btnSync == btnStable) begin
        debounceCnt <= '0;
      end else if (debounceCnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        btnStable   <= btnSync;
        debounceCnt <= '0;
      end else begin
        debounceCnt <= debounceCnt + 1'b1;
      end
    end
  end

  assign stepReq = btnStable & ~btnStableQ;

  assign bpMatch = swEnableBreakpoint & i_instrStart &
                   (i_pc == i_breakpointAddress) & ~skipBp;

  // Enable reacts in the same cycle to halt, reset and breakpoint so the
  // datapath never takes a step it should not.
  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    o_cpuClkEn = 1'b0;
    if (!i_reset && !i_halt) begin
      case (state)
        IDLE:    o_cpuClkEn = swStepNRun & stepReq;
        INSTR:   o_cpuClkEn = ~(i_instrStart & issued);
        RUN:     o_cpuClkEn = ~bpMatch & ~swStepNRun;
        BREAK:   o_cpuClkEn = 1'b0;
        default: o_cpuClkEn = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      state  <= IDLE;
      issued <= 1'b0;
      skipBp <= 1'b0;
    end else begin
      // The resumed breakpoint instruction has left its boundary.
      if (o_cpuClkEn && !i_instrStart) begin
        skipBp <= 1'b0;
      end
      case (state)
        IDLE: begin
          // Halt holds the sequencer parked so run mode cannot bounce RUN/IDLE.
          if (!i_halt) begin
            if (!swStepNRun) begin
              state <= RUN;
            end else if (swInstrNCycle && stepReq) begin
              state  <= INSTR;
              issued <= 1'b1;
            end
          end
        end
        INSTR: begin
          if (i_halt || (i_instrStart && issued)) begin
            state  <= IDLE;
            issued <= 1'b0;
          end
        end
        RUN: begin
          if (i_halt) begin
            state <= IDLE;
          end else if (bpMatch) begin
            state <= BREAK;
          end else if (swStepNRun) begin
            state <= IDLE;
          end
        end
        BREAK: begin
          if (swStepNRun) begin
            state  <= IDLE;
            skipBp <= 1'b0;
          end else if (stepReq) begin
            state  <= RUN;
            skipBp <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_running       = (state == RUN);
  assign o_breakpointHit = (state == BREAK);

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller with a 3-microcycle datapath model
// (instrStart high at microstep 0, PC increments when an instruction completes).
module tb_step_controller;

  logic        oszClk = 1'b0;
  logic        reset = 1'b1;
  logic        btnStep = 1'b0;
  logic        swInstrNCycle = 1'b0;
  logic        swStepNRun = 1'b1;
  logic        swEnableBreakpoint = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] breakpointAddress = 16'h0000;
  logic [15:0] pc;
  logic        instrStart;
  logic        cpuClkEn;
  logic        running;
  logic        breakpointHit;

  logic [1:0]  dpStep = 2'd0;
  logic [15:0] dpPc = 16'h0000;
  logic [15:0] dpPcInit = 16'h0000;
  logic        dpClear = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 oszClk = ~oszClk;

  step_controller #(
    .DEBOUNCE_CYCLES(4),
    .ADDR_WIDTH(16)
  ) dut (
    .i_oszClk(oszClk),
    .i_reset(reset),
    .i_btnStep(btnStep),
    .i_swInstrNCycle(swInstrNCycle),
    .i_swStepNRun(swStepNRun),
    .i_swEnableBreakpoint(swEnableBreakpoint),
    .i_breakpointAddress(breakpointAddress),
    .i_pc(pc),
    .i_instrStart(instrStart),
    .i_halt(halt),
    .o_cpuClkEn(cpuClkEn),
    .o_running(running),
    .o_breakpointHit(breakpointHit)
  );

  // Datapath model: 3 microcycles per instruction.
  always @(posedge oszClk) begin
    if (dpClear) begin
      dpStep <= 2'd0;
      dpPc   <= dpPcInit;
    end else if (cpuClkEn) begin
      if (dpStep == 2'd2) begin
        dpStep <= 2'd0;
        dpPc   <= dpPc + 16'd1;
      end else begin
        dpStep <= dpStep + 2'd1;
      end
    end
  end

  assign instrStart = (dpStep == 2'd0);
  assign pc         = dpPc;

  task automatic tick();
    @(posedge oszClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearDatapath(input logic [15:0] start);
    dpPcInit = start;
    dpClear  = 1'b1;
    tick();
    dpClear  = 1'b0;
  endtask

  // Press the button, release it after holdCycles edges, count enables.
  task automatic pressCount(input int window, input int holdCycles,
                            output int cnt, output int firstLat);
    btnStep  = 1'b1;
    cnt      = 0;
    firstLat = -1;
    for (int n = 1; n <= window; n++) begin
      tick();
      if (n == holdCycles) btnStep = 1'b0;
      if (cpuClkEn) begin
        cnt++;
        if (firstLat < 0) firstLat = n;
      end
    end
    btnStep = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int cnt;
    int lat;
    logic found;

    // Reset state
    repeat (3) tick();
    check("rst_en", {31'd0, cpuClkEn}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_bphit", {31'd0, breakpointHit}, 32'd0);
    reset   = 1'b0;
    dpClear = 1'b0;
    repeat (8) tick();

    // Cycle step: one pulse per press, 6 cycles after the press
    pressCount(20, 10, cnt, lat);
    check("cyc1_latency", lat, 32'd6);
    check("cyc1_count", cnt, 32'd1);
    repeat (4) tick();
    pressCount(20, 10, cnt, lat);
    check("cyc2_count", cnt, 32'd1);
    repeat (4) tick();

    // Bounce: 2-cycle toggling never settles, final hold gives one pulse
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      btnStep = ((i / 2) % 2) == 0;
      tick();
      if (cpuClkEn) cnt++;
    end
    btnStep = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (cpuClkEn) cnt++;
    end
    btnStep = 1'b0;
    check("bounce_count", cnt, 32'd1);
    repeat (12) tick();

    // Instruction step: exactly 3 enables, stop at the next boundary
    swInstrNCycle = 1'b1;
    repeat (4) tick();
    clearDatapath(16'h0010);
    pressCount(30, 10, cnt, lat);
    check("instr_latency", lat, 32'd6);
    check("instr_count", cnt, 32'd3);
    check("instr_boundary", {31'd0, instrStart}, 32'd1);
    check("instr_pc", {16'd0, pc}, 32'h0011);

    // Run mode with breakpoint at 0x0028
    clearDatapath(16'h0020);
    breakpointAddress  = 16'h0028;
    swEnableBreakpoint = 1'b1;
    swStepNRun         = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (breakpointHit) begin
        found = 1'b1;
        break;
      end
    end
    check("bp_reached", {31'd0, found}, 32'd1);
    check("bp_pc", {16'd0, pc}, 32'h0028);
    check("bp_step", {30'd0, dpStep}, 32'd0);
    check("bp_en", {31'd0, cpuClkEn}, 32'd0);
    check("bp_running", {31'd0, running}, 32'd0);
    repeat (3) tick();
    check("bp_hold_en", {31'd0, cpuClkEn}, 32'd0);
    check("bp_hold_hit", {31'd0, breakpointHit}, 32'd1);
    check("bp_hold_pc", {16'd0, pc}, 32'h0028);

    // Resume: passes 0x0028 without re-trapping
    btnStep = 1'b1;
    found   = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == 10) btnStep = 1'b0;
      if (pc == 16'h002A) begin
        found = 1'b1;
        break;
      end
    end
    btnStep = 1'b0;
    check("resume_reached", {31'd0, found}, 32'd1);
    check("resume_bphit", {31'd0, breakpointHit}, 32'd0);
    check("resume_running", {31'd0, running}, 32'd1);

    // Halt in RUN: enable drops at once, RUN left on the next edge
    halt = 1'b1;
    #1;
    check("halt_en_same", {31'd0, cpuClkEn}, 32'd0);
    check("halt_running_same", {31'd0, running}, 32'd1);
    tick();
    check("halt_running_next", {31'd0, running}, 32'd0);
    check("halt_en_next", {31'd0, cpuClkEn}, 32'd0);
    swStepNRun         = 1'b1;
    swEnableBreakpoint = 1'b0;
    repeat (4) tick();
    halt = 1'b0;
    repeat (4) tick();
    check("halt_idle", {31'd0, running}, 32'd0);

    // Reset during INSTR aborts at once
    clearDatapath(16'h0100);
    btnStep = 1'b1;
    found   = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (cpuClkEn) begin
        found = 1'b1;
        break;
      end
    end
    btnStep = 1'b0;
    check("rstinstr_step_seen", {31'd0, found}, 32'd1);
    tick();
    check("rstinstr_mid_en", {31'd0, cpuClkEn}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstinstr_en_same", {31'd0, cpuClkEn}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rstinstr_en_next", {31'd0, cpuClkEn}, 32'd0);
    check("rstinstr_running_next", {31'd0, running}, 32'd0);
    check("rstinstr_bphit_next", {31'd0, breakpointHit}, 32'd0);
    repeat (8) tick();

    // Normal instruction step after reset
    clearDatapath(16'h0200);
    pressCount(30, 10, cnt, lat);
    check("post_rst_count", cnt, 32'd3);
    check("post_rst_pc", {16'd0, pc}, 32'h0201);
    check("post_rst_boundary", {31'd0, instrStart}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Clock-enable sequencer for the EDiC CPU datapath.
- Turns the front-panel step button and the mode switches (instr/cycle, step/run, breakpoint enable) into a single CPU clock-enable.
- Supports three ways of advancing the CPU: single microcycle, single instruction, and free run with a PC breakpoint.
- Sits between the panel inputs and the datapath's microcode sequencer; the datapath advances one microcycle per cycle in which o_cpuClkEn is high.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a new step-button level.
- ADDR_WIDTH, 16: width of PC and breakpoint address.

Ports:
- i_oszClk  in  1  system clock (oscillator domain).
- i_reset  in  1  synchronous, active-high reset.
- i_btnStep  in  1  raw step button, 1 = pressed, asynchronous.
- i_swInstrNCycle  in  1  1 = instruction step, 0 = cycle step; asynchronous.
- i_swStepNRun  in  1  1 = step mode, 0 = run mode; asynchronous.
- i_swEnableBreakpoint  in  1  1 = breakpoint armed; asynchronous.
- i_breakpointAddress  in  ADDR_WIDTH  breakpoint PC; quasi-static.
- i_pc  in  ADDR_WIDTH  current program counter from the datapath.
- i_instrStart  in  1  high while the datapath microstep counter is 0 (instruction boundary); held until the next enable.
- i_halt  in  1  CPU executed HLT; level.
- o_cpuClkEn  out  1  CPU advances one microcycle when high.
- o_running  out  1  state is RUN.
- o_breakpointHit  out  1  state is BREAK.

Behaviour:
- Clock and reset: one clock, i_oszClk. Reset is synchronous and active-high on i_reset.
- Synchronizers: i_btnStep and all three switches each pass through 2 flip-flops. Everything below uses the synchronized values.
- Debounce (button):
  - A counter counts consecutive cycles in which the synchronized button differs from btnStable.
  - When the count reaches DEBOUNCE_CYCLES, btnStable takes the new value and the counter clears.
  - Any sample equal to btnStable clears the counter.
  - stepReq is a one-cycle pulse on each 0->1 transition of btnStable.
  - Press-to-stepReq latency is 2 + DEBOUNCE_CYCLES cycles.
- FSM states: IDLE, INSTR, RUN, BREAK. o_cpuClkEn is combinational from the registered state and the current inputs.
- Halt override: i_halt = 1 forces o_cpuClkEn = 0 in every state. RUN and INSTR go to IDLE on i_halt.
- IDLE:
  - Step mode, cycle step (swStepNRun = 1, swInstrNCycle = 0): stepReq gives o_cpuClkEn = 1 for exactly that cycle; stay in IDLE.
  - Step mode, instruction step (swStepNRun = 1, swInstrNCycle = 1): stepReq gives o_cpuClkEn = 1 that cycle, sets issued = 1, and goes to INSTR.
  - Run mode (swStepNRun = 0): go to RUN the next cycle. No button is needed.
- INSTR:
  - o_cpuClkEn = 1 each cycle until i_instrStart = 1 with issued = 1.
  - In that cycle o_cpuClkEn = 0 and the FSM goes to IDLE.
  - Result: one complete instruction executes, stopping at the next boundary.
  - Mode switch changes are ignored until the FSM is back in IDLE.
- RUN:
  - o_cpuClkEn = 1 every cycle.
  - Breakpoint match is swEnableBreakpoint & i_instrStart & (i_pc == i_breakpointAddress) & ~skipBp.
  - On a match: o_cpuClkEn = 0 that cycle and go to BREAK. The instruction at the breakpoint has not started.
  - swStepNRun = 1 gives o_cpuClkEn = 0 and goes to IDLE.
- BREAK:
  - o_cpuClkEn = 0.
  - stepReq sets skipBp = 1 and goes to RUN.
  - swStepNRun = 1 goes to IDLE and clears skipBp.
- skipBp:
  - Cleared on the first cycle in which o_cpuClkEn = 1 and i_instrStart = 0, i.e. once the breakpoint instruction has left its boundary.
  - Prevents re-trapping on resume.
- stepReq handling: ignored in RUN and INSTR; not queued.
- Reset:
  - State = IDLE; issued = 0; skipBp = 0; btnStable = 0; counters = 0; synchronizer flip-flops = 0.
  - All outputs = 0.
  - Reset mid-INSTR or mid-RUN aborts immediately: o_cpuClkEn = 0 in the reset cycle.
- Simultaneous events: i_halt beats the breakpoint, which beats the mode switch.
- PC compare: full ADDR_WIDTH equality, no masking.

Test Plan:
- Reset, then cycle step mode. Press the button and hold 10 cycles -> exactly one o_cpuClkEn pulse, 6 cycles after the press. Release and press again -> a second single pulse.
- Bounce: toggle i_btnStep every 2 cycles for 20 cycles, then hold 1 -> exactly one enable pulse.
- Instruction step with a datapath model whose instructions take 3 microcycles (i_instrStart high at step 0) -> exactly 3 enables after stepReq, then the FSM returns to IDLE with i_instrStart = 1.
- Run mode with breakpoint 0x0028 armed and the PC incrementing per instruction -> o_cpuClkEn stops with i_pc = 0x0028 and o_breakpointHit = 1. A step press resumes: the PC passes 0x0028 with no re-trap, and o_running = 1.
- Run mode with i_halt asserted -> o_cpuClkEn = 0 the same cycle, state IDLE, o_running = 0 the next cycle.
- Assert i_reset for 1 cycle while in INSTR -> o_cpuClkEn = 0 that cycle and all outputs 0 the next cycle. A step press after reset gives normal behaviour.
